// File: rtl/counter_timer_low_if.sv
// Register bus of the low-word counter/timer: config, reset (terminal) value
// and current value, each with write strobes and read-back data.
interface counter_timer_low_if;
  logic        reg_cfg_we;
  logic [31:0] reg_cfg_di;
  logic [31:0] reg_cfg_do;
  logic [3:0]  reg_val_we;
  logic [31:0] reg_val_di;
  logic [31:0] reg_val_do;
  logic [3:0]  reg_dat_we;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;

  modport master (
    output reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
    input  reg_cfg_do, reg_val_do, reg_dat_do
  );

  modport slave (
    input  reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
    output reg_cfg_do, reg_val_do, reg_dat_do
  );
endinterface

// File: rtl/counter_timer_low.sv
// Low 32-bit word of a chainable 64-bit counter/timer. Standalone it is a
// 32-bit up/down counter with oneshot/continuous modes; chained it strobes the
// high word on every wrap and takes the high word's stop/enable.
module counter_timer_low (
  input  logic              clkin,
  input  logic              resetn,
  counter_timer_low_if.slave bus,
  input  logic              enable_in,
  input  logic              stop_in,
  output logic              strobe,
  output logic              is_offset,
  output logic              stop_out,
  output logic              enable_out,
  output logic              irq_out
);
  logic        enable, oneshot, updown, chain, irq_ena;
  logic [31:0] value_reset, value_cur;
  logic        lastenable;
  logic [31:0] cur_next, cur_load, val_load;
  logic        stop_next, irq_next;
  logic        loc_enable, dat_write, at_limit, terminal, wraps;
  logic [31:0] start_val, limit_val, stepped;

  // Byte-lane merge of bus writes with the held register contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign cur_load[gi*8 +: 8] = bus.reg_dat_we[gi] ? bus.reg_dat_di[gi*8 +: 8] : value_cur[gi*8 +: 8];
    assign val_load[gi*8 +: 8] = bus.reg_val_we[gi] ? bus.reg_val_di[gi*8 +: 8] : value_reset[gi*8 +: 8];
  end

  // In chained mode the high word must also be enabled for the pair to run.
  assign loc_enable = chain ? (enable & enable_in) : enable;
  assign dat_write  = |bus.reg_dat_we;
  // Up counts run 0..value_reset, down counts run value_reset..0.
  assign start_val  = updown ? 32'd0 : value_reset;
  assign limit_val  = updown ? value_reset : 32'd0;
  assign at_limit   = (value_cur == limit_val);
  assign terminal   = stop_in & at_limit;
  assign stepped    = updown ? value_cur + 32'd1 : value_cur - 32'd1;
  assign wraps      = updown ? (value_cur == 32'hFFFF_FFFF) : (value_cur == 32'd0);

  // Strobe is combinational so the high word advances on the same edge the low word wraps.
  assign strobe     = chain & loc_enable & lastenable & ~dat_write & ~terminal & wraps;
  assign is_offset  = chain & updown & (value_cur == 32'hFFFF_FFFF);
  assign enable_out = enable;

  assign bus.reg_cfg_do = {27'd0, irq_ena, chain, updown, oneshot, enable};
  assign bus.reg_val_do = value_reset;
  assign bus.reg_dat_do = value_cur;

  // Next value/stop/irq: bus write first, then disable, start, and counting.
  always_comb begin
    cur_next  = dat_write ? cur_load : value_cur;
    stop_next = stop_out;
    irq_next  = irq_out;
    if (!dat_write) begin
      if (!loc_enable) begin
        stop_next = 1'b0;
      end else begin
        irq_next = irq_ena & stop_out;
        if (!lastenable) begin
          cur_next  = start_val;
          stop_next = 1'b0;
        end else if (!chain) begin
          if (at_limit) begin
            if (oneshot) begin
              stop_next = 1'b1;
            end else begin
              cur_next  = start_val;
              stop_next = 1'b0;
            end
          end else begin
            cur_next  = stepped;
            stop_next = (stepped == 32'd0);
          end
        end else if (terminal) begin
          // 64-bit terminal count: continuous mode flags it for one cycle only.
          stop_next = 1'b1;
          if (!oneshot) cur_next = start_val;
        end else begin
          cur_next = stepped;
          if (!oneshot) stop_next = 1'b0;
        end
      end
    end
  end

  // Config register; new settings apply from the following cycle.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      {irq_ena, chain, updown, oneshot, enable} <= 5'd0;
    end else if (bus.reg_cfg_we) begin
      {irq_ena, chain, updown, oneshot, enable} <= bus.reg_cfg_di[4:0];
    end
  end

  // Counter state, terminal value and status flags.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      value_reset <= 32'd0;
      value_cur   <= 32'd0;
      lastenable  <= 1'b0;
      stop_out    <= 1'b0;
      irq_out     <= 1'b0;
    end else begin
      value_reset <= val_load;
      value_cur   <= cur_next;
      lastenable  <= loc_enable;
      stop_out    <= stop_next;
      irq_out     <= irq_next;
    end
  end
endmodule

// File: tb/tb_counter_timer_low.sv
// Bench for counter_timer_low: directed scenarios plus randomized traffic
// against a range-based reference model of the low word.
module tb_counter_timer_low;
  logic clkin = 1'b0;
  logic resetn = 1'b1;
  logic enable_in = 1'b0;
  logic stop_in = 1'b0;
  logic strobe, is_offset, stop_out, enable_out, irq_out;

  counter_timer_low_if bus();

  counter_timer_low dut (
    .clkin(clkin), .resetn(resetn), .bus(bus),
    .enable_in(enable_in), .stop_in(stop_in),
    .strobe(strobe), .is_offset(is_offset), .stop_out(stop_out),
    .enable_out(enable_out), .irq_out(irq_out)
  );

  always #5 clkin = ~clkin;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic        m_enable, m_oneshot, m_up, m_chain, m_irqena;
  logic [31:0] m_rst, m_cur;
  logic        m_last, m_stop, m_irq;

  task automatic model_reset();
    {m_enable, m_oneshot, m_up, m_chain, m_irqena} = 5'd0;
    m_rst = 0; m_cur = 0; m_last = 0; m_stop = 0; m_irq = 0;
  endtask

  function automatic logic m_loc();
    return m_chain ? (m_enable & enable_in) : m_enable;
  endfunction

  // High word advances when a counting step would carry/borrow out of 32 bits.
  function automatic logic m_strobe();
    logic [32:0] wide;
    logic        term;
    wide = m_up ? {1'b0, m_cur} + 33'd1 : {1'b0, m_cur} - 33'd1;
    term = stop_in && (m_cur == (m_up ? m_rst : 32'd0));
    return m_chain && m_loc() && m_last && (bus.reg_dat_we == 4'd0) && !term && wide[32];
  endfunction

  function automatic logic m_offset();
    logic [32:0] wide;
    wide = {1'b0, m_cur} + 33'd1;
    return m_chain && m_up && wide[32];
  endfunction

  // One clock of the model: range [first .. last_v] walked in the count direction.
  task automatic model_clock();
    logic        loc, prev_stop;
    logic [31:0] first, last_v;
    loc = m_loc();
    prev_stop = m_stop;
    first  = m_up ? 32'd0 : m_rst;
    last_v = m_up ? m_rst : 32'd0;
    if (bus.reg_dat_we != 4'd0) begin
      for (int b = 0; b < 4; b++)
        if (bus.reg_dat_we[b]) m_cur[b*8 +: 8] = bus.reg_dat_di[b*8 +: 8];
    end else if (!loc) begin
      m_stop = 0;
    end else begin
      m_irq = m_irqena & prev_stop;
      if (!m_last) begin
        m_cur = first; m_stop = 0;
      end else if (m_cur == last_v && (!m_chain || stop_in)) begin
        if (m_oneshot) m_stop = 1;
        else begin m_cur = first; m_stop = m_chain; end
      end else begin
        m_cur = m_up ? m_cur + 1 : m_cur - 1;
        if (!m_chain) m_stop = (m_cur == 0);
        else if (!m_oneshot) m_stop = 0;
      end
    end
    for (int b = 0; b < 4; b++)
      if (bus.reg_val_we[b]) m_rst[b*8 +: 8] = bus.reg_val_di[b*8 +: 8];
    if (bus.reg_cfg_we) {m_irqena, m_chain, m_up, m_oneshot, m_enable} = bus.reg_cfg_di[4:0];
    m_last = loc;
  endtask

  // Advance one clock; single-cycle writes are released after the edge.
  task automatic tick();
    if (resetn) model_clock(); else model_reset();
    @(posedge clkin); #1;
    bus.reg_cfg_we = 0; bus.reg_val_we = 0; bus.reg_dat_we = 0;
    #1;
  endtask

  task automatic wr_cfg(input logic [31:0] v);
    bus.reg_cfg_we = 1; bus.reg_cfg_di = v; tick();
  endtask

  task automatic wr_val(input logic [3:0] we, input logic [31:0] v);
    bus.reg_val_we = we; bus.reg_val_di = v; tick();
  endtask

  task automatic wr_dat(input logic [3:0] we, input logic [31:0] v);
    bus.reg_dat_we = we; bus.reg_dat_di = v; tick();
  endtask

  task automatic stop_all();
    wr_cfg(32'h0); tick();
  endtask

  task automatic test_reset();
    #1 resetn = 0; #1;
    total++; if (bus.reg_cfg_do !== 32'd0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", bus.reg_cfg_do); end
    total++; if (bus.reg_val_do !== 32'd0) begin bad++; $display("FAIL reset_val got=%h exp=0", bus.reg_val_do); end
    total++; if (bus.reg_dat_do !== 32'd0) begin bad++; $display("FAIL reset_dat got=%h exp=0", bus.reg_dat_do); end
    total++; if ({stop_out, irq_out, strobe, is_offset, enable_out} !== 5'd0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {stop_out, irq_out, strobe, is_offset, enable_out});
    end
    tick(); tick();
    resetn = 1;
    tick();
    total++; if (bus.reg_dat_do !== 32'd0) begin bad++; $display("FAIL post_reset_dat got=%h exp=0", bus.reg_dat_do); end
    $display("reset checked");
  endtask

  task automatic test_down_oneshot();
    logic [31:0] exp_cur [6] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    logic [5:0]  exp_stop = 6'b111000;
    logic [5:0]  exp_irq  = 6'b110000;
    wr_val(4'hF, 32'd3);
    wr_cfg(32'h13);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (bus.reg_dat_do !== exp_cur[k]) begin bad++; $display("FAIL oneshot_cur[%0d] got=%h exp=%h", k, bus.reg_dat_do, exp_cur[k]); end
      total++; if (stop_out !== exp_stop[k]) begin bad++; $display("FAIL oneshot_stop[%0d] got=%b exp=%b", k, stop_out, exp_stop[k]); end
      total++; if (irq_out !== exp_irq[k]) begin bad++; $display("FAIL oneshot_irq[%0d] got=%b exp=%b", k, irq_out, exp_irq[k]); end
      $display("down oneshot cycle %0d cur=%0d stop=%b irq=%b", k, bus.reg_dat_do, stop_out, irq_out);
    end
    stop_all();
  endtask

  task automatic test_up_continuous();
    logic [31:0] exp_cur [6] = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
    wr_val(4'hF, 32'd2);
    wr_cfg(32'h05);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (bus.reg_dat_do !== exp_cur[k]) begin bad++; $display("FAIL upcont_cur[%0d] got=%h exp=%h", k, bus.reg_dat_do, exp_cur[k]); end
      total++; if ({stop_out, strobe, is_offset} !== 3'b000) begin
        bad++; $display("FAIL upcont_flags[%0d] got=%b exp=000", k, {stop_out, strobe, is_offset});
      end
      $display("up continuous cycle %0d cur=%0d", k, bus.reg_dat_do);
    end
    stop_all();
  endtask

  task automatic test_chain_up();
    int hi = 0;
    enable_in = 1; stop_in = 0;
    wr_cfg(32'h0D);
    tick();
    wr_dat(4'hF, 32'hFFFF_FFFE);
    total++; if ({strobe, is_offset} !== 2'b00) begin bad++; $display("FAIL chain_fffe got=%b exp=00", {strobe, is_offset}); end
    if (strobe) hi++;
    tick();
    total++; if (bus.reg_dat_do !== 32'hFFFF_FFFF) begin bad++; $display("FAIL chain_ffff_cur got=%h exp=ffffffff", bus.reg_dat_do); end
    total++; if ({strobe, is_offset} !== 2'b11) begin bad++; $display("FAIL chain_ffff got=%b exp=11", {strobe, is_offset}); end
    if (strobe) hi++;
    tick();
    total++; if (bus.reg_dat_do !== 32'd0) begin bad++; $display("FAIL chain_wrap_cur got=%h exp=0", bus.reg_dat_do); end
    total++; if ({strobe, is_offset} !== 2'b00) begin bad++; $display("FAIL chain_wrap got=%b exp=00", {strobe, is_offset}); end
    total++; if (hi !== 1) begin bad++; $display("FAIL chain_hi got=%0d exp=1", hi); end
    if (strobe) hi++;
    tick();
    total++; if (hi !== 1 || bus.reg_dat_do !== 32'd1) begin bad++; $display("FAIL chain_after got=%0d/%h exp=1/1", hi, bus.reg_dat_do); end
    $display("chain up: high word count=%0d", hi);
    stop_all();
    enable_in = 0;
  endtask

  task automatic test_chain_down_terminal();
    enable_in = 1; stop_in = 0;
    wr_val(4'hF, 32'd5);
    wr_cfg(32'h09);
    tick();
    wr_dat(4'hF, 32'd1);
    tick();
    total++; if (bus.reg_dat_do !== 32'd0) begin bad++; $display("FAIL cdown_zero got=%h exp=0", bus.reg_dat_do); end
    total++; if (strobe !== 1'b1) begin bad++; $display("FAIL cdown_wrap_strobe got=%b exp=1", strobe); end
    stop_in = 1; #1;
    total++; if (strobe !== 1'b0) begin bad++; $display("FAIL cdown_term_strobe got=%b exp=0", strobe); end
    tick();
    total++; if (bus.reg_dat_do !== 32'd5 || stop_out !== 1'b1) begin
      bad++; $display("FAIL cdown_reload got=%h/%b exp=5/1", bus.reg_dat_do, stop_out);
    end
    stop_in = 0;
    tick();
    total++; if (bus.reg_dat_do !== 32'd4 || stop_out !== 1'b0) begin
      bad++; $display("FAIL cdown_after got=%h/%b exp=4/0", bus.reg_dat_do, stop_out);
    end
    $display("chain down terminal: reloaded, stop pulse checked");
    stop_all();
    enable_in = 0;
  endtask

  task automatic test_write_priority();
    enable_in = 1; stop_in = 0;
    wr_cfg(32'h0D);
    tick();
    wr_dat(4'hF, 32'hFFFF_FFFF);
    total++; if (strobe !== 1'b1) begin bad++; $display("FAIL prio_pre_strobe got=%b exp=1", strobe); end
    bus.reg_dat_we = 4'b0001; bus.reg_dat_di = 32'h5555_55AA; #1;
    total++; if (strobe !== 1'b0) begin bad++; $display("FAIL prio_strobe got=%b exp=0", strobe); end
    tick();
    total++; if (bus.reg_dat_do !== 32'hFFFF_FFAA) begin bad++; $display("FAIL prio_byte got=%h exp=ffffffaa", bus.reg_dat_do); end
    tick();
    total++; if (bus.reg_dat_do !== 32'hFFFF_FFAB) begin bad++; $display("FAIL prio_resume got=%h exp=ffffffab", bus.reg_dat_do); end
    $display("write priority: cur=%h", bus.reg_dat_do);
    stop_all();
    enable_in = 0;
  endtask

  task automatic test_reset_midcount();
    wr_val(4'hF, 32'h100);
    wr_cfg(32'h05);
    tick(); tick(); tick();
    #2 resetn = 0; #1;
    total++; if ({bus.reg_cfg_do, bus.reg_val_do, bus.reg_dat_do} !== 96'd0) begin
      bad++; $display("FAIL midreset_regs got=%h/%h/%h exp=0", bus.reg_cfg_do, bus.reg_val_do, bus.reg_dat_do);
    end
    total++; if ({stop_out, irq_out, strobe, is_offset, enable_out} !== 5'd0) begin
      bad++; $display("FAIL midreset_flags got=%b exp=00000", {stop_out, irq_out, strobe, is_offset, enable_out});
    end
    model_reset();
    resetn = 1;
    wr_cfg(32'h01);
    tick();
    total++; if (bus.reg_dat_do !== 32'd0 || bus.reg_val_do !== 32'd0) begin
      bad++; $display("FAIL midreset_restart got=%h/%h exp=0/0", bus.reg_dat_do, bus.reg_val_do);
    end
    tick();
    total++; if (bus.reg_dat_do !== m_cur) begin bad++; $display("FAIL midreset_run got=%h exp=%h", bus.reg_dat_do, m_cur); end
    $display("reset mid-count: restarted at %h", bus.reg_dat_do);
    stop_all();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      enable_in = ($urandom_range(0, 9) != 0);
      stop_in   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom;
        bus.reg_cfg_we = 1; bus.reg_cfg_di = r;
        bus.reg_cfg_di[0] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 29) == 0) begin
        bus.reg_val_we = 4'($urandom_range(1, 15)); bus.reg_val_di = $urandom_range(0, 6);
      end
      if ($urandom_range(0, 24) == 0) begin
        bus.reg_dat_we = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
        case ($urandom_range(0, 3))
          0: bus.reg_dat_di = 32'hFFFF_FFFE;
          1: bus.reg_dat_di = 32'hFFFF_FFFF;
          2: bus.reg_dat_di = 32'd1;
          default: bus.reg_dat_di = $urandom_range(0, 8);
        endcase
      end
      #1;
      total++; if (strobe !== m_strobe()) begin bad++; $display("FAIL rnd_strobe[%0d] got=%b exp=%b", i, strobe, m_strobe()); end
      total++; if (is_offset !== m_offset()) begin bad++; $display("FAIL rnd_offset[%0d] got=%b exp=%b", i, is_offset, m_offset()); end
      tick();
      total++; if (bus.reg_dat_do !== m_cur) begin bad++; $display("FAIL rnd_cur[%0d] got=%h exp=%h", i, bus.reg_dat_do, m_cur); end
      total++; if (bus.reg_val_do !== m_rst) begin bad++; $display("FAIL rnd_val[%0d] got=%h exp=%h", i, bus.reg_val_do, m_rst); end
      total++; if (bus.reg_cfg_do !== {27'd0, m_irqena, m_chain, m_up, m_oneshot, m_enable}) begin
        bad++; $display("FAIL rnd_cfg[%0d] got=%h exp=%h", i, bus.reg_cfg_do, {27'd0, m_irqena, m_chain, m_up, m_oneshot, m_enable});
      end
      total++; if ({stop_out, irq_out, enable_out} !== {m_stop, m_irq, m_enable}) begin
        bad++; $display("FAIL rnd_flags[%0d] got=%b exp=%b", i, {stop_out, irq_out, enable_out}, {m_stop, m_irq, m_enable});
      end
      $display("rnd %0d cfg=%h cur=%h stop=%b irq=%b", i, bus.reg_cfg_do[4:0], bus.reg_dat_do, stop_out, irq_out);
    end
  endtask

  initial begin
    bus.reg_cfg_we = 0; bus.reg_cfg_di = 0;
    bus.reg_val_we = 0; bus.reg_val_di = 0;
    bus.reg_dat_we = 0; bus.reg_dat_di = 0;
    model_reset();
    test_reset();
    test_down_oneshot();
    test_up_continuous();
    test_chain_up();
    test_chain_down_terminal();
    test_write_priority();
    test_reset_midcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_timer_low.md
Name: counter_timer_low

Overview:
- Low 32-bit word of the Caravel 64-bit chained counter/timer. Also works as a standalone 32-bit counter/timer.
- In chained mode it drives the high-word counter:
  - strobe on every low-word wrap,
  - is_offset for the high word's compare,
  - stop_out at the 64-bit terminal count.
- It consumes the high word's enable_out and stop_out.
- The register interface is identical to the high-word core, so the same wishbone wrapper style applies.

Parameters:
- None. Widths are fixed at 32 bits.

Ports:
- clkin  input  1  clock.
- resetn  input  1  reset, asynchronous, active-low.
- reg_cfg_we  input  1  config write enable.
- reg_cfg_di  input  32  config write data.
- reg_cfg_do  output  32  {27'd0, irq_ena, chain, updown, oneshot, enable}.
- reg_val_we  input  4  per-byte write enable, reset (terminal) value.
- reg_val_di  input  32  reset value write data.
- reg_val_do  output  32  value_reset.
- reg_dat_we  input  4  per-byte write enable, current value.
- reg_dat_di  input  32  current value write data.
- reg_dat_do  output  32  value_cur.
- enable_in  input  1  enable from the high word.
- stop_in  input  1  high word has reached its terminal value.
- strobe  output  1  count strobe to the high word (combinational).
- is_offset  output  1  high word compares its value+1 (combinational).
- stop_out  output  1  stop to the high word / status (registered).
- enable_out  output  1  equals the enable config bit.
- irq_out  output  1  interrupt (registered).

Behaviour:
- Reset values: all config bits, value_reset, value_cur, lastenable, stop_out and irq_out are 0.
  - Consequently strobe = is_offset = enable_out = 0.
- Config register:
  - reg_cfg_we loads bit0 enable, bit1 oneshot, bit2 updown (1 = up), bit3 chain, bit4 irq_ena.
- value_reset: byte-wise write through reg_val_we, no other updates.
- loc_enable = chain ? (enable & enable_in) : enable. lastenable <= loc_enable every cycle.
- Priority per cycle, highest first:
  1. reg_dat_we != 0: byte-wise load of value_cur. No counting. stop_out and irq_out hold.
  2. loc_enable == 0: value_cur holds, stop_out <= 0.
  3. loc_enable rising (lastenable == 0): value_cur <= updown ? 0 : value_reset, stop_out <= 0.
  4. Counting, as defined below.
- Whenever loc_enable == 1 and no dat write: irq_out <= irq_ena & stop_out (one cycle after stop).
- Standalone counting (chain = 0), up:
  - value_cur == value_reset: continuous -> value_cur <= 0, stop_out <= 0; oneshot -> hold, stop_out <= 1.
  - Otherwise value_cur <= value_cur + 1, and stop_out <= (value_cur + 1 == 0).
- Standalone counting (chain = 0), down:
  - value_cur == 0: continuous -> reload value_reset, stop_out <= 0; oneshot -> hold, stop_out <= 1.
  - Otherwise value_cur <= value_cur - 1, and stop_out <= (value_cur - 1 == 0).
- Chained counting (chain = 1): counts every cycle.
  - terminal = stop_in & (updown ? value_cur == value_reset : value_cur == 0).
  - When terminal:
    - oneshot: value_cur holds, stop_out <= 1.
    - continuous: value_cur <= updown ? 0 : value_reset, stop_out <= 1 for exactly this one cycle.
  - When not terminal: value_cur <= value_cur ± 1 with 32-bit wrap, and stop_out <= 0 (continuous) or holds (oneshot).
- strobe = chain & loc_enable & lastenable & ~(reg_dat_we != 0) & ~terminal & (updown ? value_cur == 32'hFFFFFFFF : value_cur == 0).
  - Strobe is asserted in the cycle whose clock edge wraps the low word, so both words update on the same edge.
- is_offset = chain & updown & (value_cur == 32'hFFFFFFFF).
- Both strobe and is_offset are 0 whenever chain = 0.
- Asynchronous reset mid-count immediately clears all state. Counting restarts only via the loc_enable rising-edge rule.
- Simultaneous reg_cfg_we and reg_dat_we are legal:
  - the config takes effect next cycle;
  - the dat write wins this cycle.

Test Plan:
- Standalone down, oneshot:
  - Stimulus: value_reset = 3, cfg = 0x13 (enable, oneshot, irq_ena).
  - Required: value_cur 3,2,1,0; stop_out = 1 from the edge that loads 0; irq_out = 1 one cycle later; value holds at 0.
- Standalone up, continuous:
  - Stimulus: value_reset = 2, cfg = 0x05.
  - Required: value_cur repeats 0,1,2,0,1,2; stop_out stays 0; strobe and is_offset stay 0.
- Chained up, paired with a high-word model (enable_in = 1):
  - Stimulus: cfg = 0x0D; after start, dat write 0xFFFFFFFE.
  - Required: is_offset = 1 while value_cur is 0xFFFFFFFF; strobe is a single-cycle pulse as value_cur wraps to 0.
- Chained down, continuous terminal:
  - Stimulus: value_reset = 5; stop_in forced to 1 while value_cur == 0.
  - Required: value_cur reloads 5; stop_out is a one-cycle pulse; strobe stays 0 in that cycle.
- Write priority:
  - Stimulus: while counting, reg_dat_we = 4'b0001 with di = 0xAA.
  - Required: only byte 0 changes that cycle, no increment, strobe = 0; counting resumes from the written value.
- Reset mid-operation:
  - Stimulus: assert resetn = 0 asynchronously mid-count.
  - Required: all outputs 0 immediately.
  - After release and re-enable (cfg = 0x01): value_cur loads value_reset (now 0) and the counter restarts.
